card_draw: RTL and testbench

Consumer end of the free-running entropy counter in the BlackJack datapath. On a draw request from the game FSM it samples the counter value and reduces it to a card rank 1..13. It tracks a 52-card deck so that no rank is dealt more than four times, and returns the card with a valid pulse. It then holds for two seconds, measured in 2 kHz ticks, and signals the FSM with `o_TwoSec`.

---
 rtl/blackjack_pkg.sv | 30 +++
 rtl/card_draw_if.sv | 28 ++
 rtl/mod13_reducer.sv | 34 +++
 rtl/card_draw.sv | 117 +++++++++++
 tb/tb_card_draw.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/blackjack_pkg.sv
// Shared BlackJack types: draw FSM states, deck geometry
// and the rank-to-points mapping used by the score path.
package blackjack_pkg;

  localparam int RANKS     = 13;
  localparam int SUITS     = 4;
  localparam int DECK_SIZE = 52;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    CHECK,
    COMMIT,
    HOLD
  } draw_state_t;

  // Ace counts 11, face cards 10, others face value.
  function automatic logic [3:0] rank_points(
    input logic [3:0] rank
  );
    logic [3:0] p;
    unique case (1'b1)
      (rank == 4'd1): p = 4'd11;
      (rank > 4'd10): p = 4'd10;
      default:        p = rank;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/card_draw_if.sv
// Draw handshake between the game FSM (master) and card_draw (slave).
// Carries tick, counter sample, draw/shuffle requests and card results.
interface card_draw_if #(
  parameter int WIDTH = 12
);
  logic             i_Tick2K;
  logic [WIDTH-1:0] i_Count;
  logic             i_Draw;
  logic             i_Shuffle;
  logic             o_Busy;
  logic             o_Valid;
  logic [3:0]       o_Card;
  logic [3:0]       o_Points;
  logic             o_TwoSec;
  logic             o_Empty;

  modport master (
    output i_Tick2K, i_Count, i_Draw, i_Shuffle,
    input  o_Busy, o_Valid, o_Card, o_Points,
    input  o_TwoSec, o_Empty
  );

  modport slave (
    input  i_Tick2K, i_Count, i_Draw, i_Shuffle,
    output o_Busy, o_Valid, o_Card, o_Points,
    output o_TwoSec, o_Empty
  );
endinterface

// File: rtl/mod13_reducer.sv
// Iterative subtract-13 engine: start loads value, run steps it down.
// done is high while running once the residue is below 13; rem is it.
module mod13_reducer
  import blackjack_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] value,
  output logic             done,
  output logic [3:0]       rem
);

  logic [WIDTH-1:0] r;
  logic             lt13;

  assign lt13 = r < WIDTH'(RANKS);
  assign done = run && lt13;
  assign rem  = r[3:0];

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      r <= '0;
    end else if (start) begin
      r <= value;
    end else if (run && !lt13) begin
      r <= r - WIDTH'(RANKS);
    end
  end

endmodule

// File: rtl/card_draw.sv
// Card dealer: samples the entropy counter, reduces it to a rank,
// probes the 52-card deck, pulses the card, then holds two seconds.
module card_draw
  import blackjack_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int TICKS_2S = 4000
) (
  input logic        clk_50M,
  input logic        i_Reset,
  card_draw_if.slave bus
);

  localparam int TW = (TICKS_2S > 1) ? $clog2(TICKS_2S) : 1;

  draw_state_t      state;
  logic [12:0][2:0] used;
  logic [5:0]       remaining;
  logic [TW-1:0]    tick;
  logic [3:0]       idx;
  logic [3:0]       card_q;
  logic [3:0]       pts_q;
  logic             valid_q;
  logic             twosec_q;
  logic             red_start;
  logic             red_run;
  logic             red_done;
  logic [3:0]       red_rem;

  // Shuffle has priority over a simultaneous draw.
  assign red_start = (state == IDLE) && !bus.i_Shuffle
                  && bus.i_Draw && (remaining != 6'd0);
  assign red_run   = (state == REDUCE);

  mod13_reducer #(
    .WIDTH (WIDTH)
  ) u_red (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .start   (red_start),
    .run     (red_run),
    .value   (bus.i_Count),
    .done    (red_done),
    .rem     (red_rem)
  );

  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state     <= IDLE;
      used      <= '0;
      remaining <= 6'(DECK_SIZE);
      tick      <= '0;
      idx       <= '0;
      card_q    <= '0;
      pts_q     <= '0;
      valid_q   <= 1'b0;
      twosec_q  <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      twosec_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_Shuffle) begin
            used      <= '0;
            remaining <= 6'(DECK_SIZE);
          end else if (red_start) begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (red_done) begin
            idx   <= red_rem;
            state <= CHECK;
          end
        end
        CHECK: begin
          // Linear probe; ends since some rank has a card left.
          if (used[idx] < 3'(SUITS)) begin
            state <= COMMIT;
          end else if (idx == 4'(RANKS - 1)) begin
            idx <= '0;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        COMMIT: begin
          used[idx] <= used[idx] + 3'd1;
          remaining <= remaining - 6'd1;
          card_q    <= idx + 4'd1;
          pts_q     <= rank_points(idx + 4'd1);
          valid_q   <= 1'b1;
          tick      <= '0;
          state     <= HOLD;
        end
        HOLD: begin
          if (bus.i_Tick2K) begin
            if (tick == TW'(TICKS_2S - 1)) begin
              twosec_q <= 1'b1;
              state    <= IDLE;
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Busy   = (state != IDLE);
  assign bus.o_Empty  = (remaining == 6'd0);
  assign bus.o_Valid  = valid_q;
  assign bus.o_TwoSec = twosec_q;
  assign bus.o_Card   = card_q;
  assign bus.o_Points = pts_q;

endmodule

// File: tb/tb_card_draw.sv
// Directed bench for card_draw: draw latency, deck exhaustion,
// probing, hold timing, shuffle priority and mid-draw reset.
module tb_card_draw;

  logic clk_50M = 1'b0;
  logic i_Reset;

  int total = 0;
  int bad   = 0;
  int tick_period = 3;
  int tcnt = 0;

  card_draw_if #(.WIDTH(12)) bus ();

  card_draw #(
    .WIDTH    (12),
    .TICKS_2S (4)
  ) dut (
    .clk_50M (clk_50M),
    .i_Reset (i_Reset),
    .bus     (bus.slave)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample point is #1 after the edge, then the tick
  // for the next edge is driven.
  task automatic cyc();
    @(posedge clk_50M);
    #1;
    tcnt++;
    bus.i_Tick2K = ((tcnt % tick_period) == 0);
  endtask

  task automatic do_draw(input int v, output int card,
                         output int pts, output int lat);
    int n;
    bit got;
    bus.i_Count = 12'(v);
    bus.i_Draw  = 1'b1;
    n = 0;
    got = 0;
    card = 0;
    pts = 0;
    while (!got && n < 2000) begin
      cyc();
      n++;
      bus.i_Draw = 1'b0;
      if (bus.o_Valid) got = 1;
    end
    chk("valid_seen", int'(got), 1);
    card = int'(bus.o_Card);
    pts  = int'(bus.o_Points);
    lat  = n;
    n = 0;
    got = 0;
    while (!got && n < 2000) begin
      cyc();
      n++;
      if (bus.o_TwoSec) got = 1;
    end
    chk("twosec_seen", int'(got), 1);
  endtask

  task automatic shuffle();
    bus.i_Shuffle = 1'b1;
    cyc();
    bus.i_Shuffle = 1'b0;
  endtask

  initial begin
    int card, pts, lat, n, ticks, nval;
    int cnt [13];
    bit tap, seen;

    bus.i_Tick2K  = 1'b0;
    bus.i_Count   = '0;
    bus.i_Draw    = 1'b0;
    bus.i_Shuffle = 1'b0;
    i_Reset = 1'b1;
    cyc();
    cyc();
    i_Reset = 1'b0;

    chk("rst_busy",   int'(bus.o_Busy),   0);
    chk("rst_valid",  int'(bus.o_Valid),  0);
    chk("rst_card",   int'(bus.o_Card),   0);
    chk("rst_points", int'(bus.o_Points), 0);
    chk("rst_twosec", int'(bus.o_TwoSec), 0);
    chk("rst_empty",  int'(bus.o_Empty),  0);
    chk("rst_remain", int'(dut.remaining), 52);

    // 100 mod 13 = 9 -> card 10; 8 REDUCE cycles, no probe.
    do_draw(100, card, pts, lat);
    chk("c100_card", card, 10);
    chk("c100_pts",  pts,  10);
    chk("c100_lat",  lat,  11);
    chk("c100_rem",  int'(dut.remaining), 51);

    // Four aces, then the probe moves to rank 2.
    shuffle();
    for (int k = 0; k < 4; k++) begin
      do_draw(0, card, pts, lat);
      chk("ace_card", card, 1);
      chk("ace_pts",  pts,  11);
      chk("ace_lat",  lat,  4);
    end
    do_draw(0, card, pts, lat);
    chk("probe_card", card, 2);
    chk("probe_pts",  pts,  2);
    chk("probe_lat",  lat,  5);

    // Hold timing with sparse ticks; draws in HOLD are ignored.
    shuffle();
    tick_period = 10;
    bus.i_Count = 12'd5;
    bus.i_Draw  = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      cyc();
      n++;
      bus.i_Draw = 1'b0;
      if (bus.o_Valid) seen = 1;
    end
    chk("hold_valid", int'(seen), 1);
    chk("hold_card",  int'(bus.o_Card), 6);
    chk("hold_busy",  int'(bus.o_Busy), 1);
    ticks = 0;
    nval = 0;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      tap = bus.i_Tick2K;
      bus.i_Draw = (n == 5) || (n == 17);
      cyc();
      n++;
      if (tap) ticks++;
      if (bus.o_Valid) nval++;
      if (bus.o_TwoSec) seen = 1;
    end
    bus.i_Draw = 1'b0;
    chk("hold_twosec", int'(seen), 1);
    chk("hold_ticks",  ticks, 4);
    chk("hold_busy_fall", int'(bus.o_Busy), 0);
    chk("hold_nvalid", nval, 0);
    cyc();
    chk("twosec_pulse", int'(bus.o_TwoSec), 0);
    chk("idle_busy",    int'(bus.o_Busy),   0);
    tick_period = 3;

    // Exhaust the deck: each rank exactly four times.
    shuffle();
    for (int r = 0; r < 13; r++) cnt[r] = 0;
    for (int k = 0; k < 52; k++) begin
      do_draw(12, card, pts, lat);
      if (card >= 1 && card <= 13) cnt[card-1]++;
    end
    for (int r = 0; r < 13; r++) chk("rank_count", cnt[r], 4);
    chk("deck_empty", int'(bus.o_Empty), 1);
    bus.i_Count = 12'd12;
    bus.i_Draw  = 1'b1;
    nval = 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (bus.o_Valid) nval++;
      if (bus.o_Busy) n++;
    end
    bus.i_Draw = 1'b0;
    chk("empty_nvalid", nval, 0);
    chk("empty_busy",   n,    0);
    shuffle();
    chk("shuf_empty",  int'(bus.o_Empty),  0);
    chk("shuf_remain", int'(dut.remaining), 52);

    // Shuffle beats a simultaneous draw.
    do_draw(30, card, pts, lat);
    chk("c30_card", card, 5);
    chk("c30_rem",  int'(dut.remaining), 51);
    bus.i_Shuffle = 1'b1;
    bus.i_Draw    = 1'b1;
    cyc();
    bus.i_Shuffle = 1'b0;
    bus.i_Draw    = 1'b0;
    chk("sd_busy",   int'(bus.o_Busy),   0);
    chk("sd_remain", int'(dut.remaining), 52);
    cyc();
    chk("sd_busy2",  int'(bus.o_Busy),   0);

    // Reset in the middle of a long REDUCE.
    bus.i_Count = 12'd4095;
    bus.i_Draw  = 1'b1;
    cyc();
    bus.i_Draw = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("pre_rst_busy", int'(bus.o_Busy), 1);
    i_Reset = 1'b1;
    cyc();
    i_Reset = 1'b0;
    chk("mid_rst_busy",   int'(bus.o_Busy),   0);
    chk("mid_rst_card",   int'(bus.o_Card),   0);
    chk("mid_rst_remain", int'(dut.remaining), 52);
    do_draw(4095, card, pts, lat);
    chk("c4095_card", card, 1);
    chk("c4095_pts",  pts,  11);
    chk("c4095_lat",  lat,  319);
    chk("c4095_rem",  int'(dut.remaining), 51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
